mmu_tlb_walker: RTL and testbench

- Parametrised successor to the core's single-walk MMU: translates one cbus request at a time from virtual to physical.
- Supports configurable Sv39/Sv48 depth, superpages, leaf permission checks with page-fault reporting, and a small fully-associative TLB flushed by sfence.
- Sits between core memory port (req_virt/resp_virt) and the cbus arbiter (req_phys/resp_phys).

---
 rtl/mmu_tlb_walker.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mmu_tlb_walker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_tlb_walker.sv
// Single-walk Sv39/Sv48 MMU: translates one cbus request at a time through a small
// fully-associative TLB and a page-table walker.
package mmu_tlb_walker_pkg;
    typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef struct packed {
        logic d;
        logic a;
        logic u;
        logic x;
        logic w;
        logic r;
    } pte_flags_t;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;
endpackage

module mmu_tlb_walker
    import mmu_tlb_walker_pkg::*;
#(
    parameter int unsigned LEVELS      = 3,
    parameter int unsigned TLB_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] satp,
    input  logic [1:0]  priviledge_mode,
    input  logic        sfence,
    input  cbus_req_t   req_virt,
    output cbus_resp_t  resp_virt,
    output cbus_req_t   req_phys,
    input  cbus_resp_t  resp_phys,
    output logic        skip,
    output logic        page_fault
);
    localparam int unsigned VPN_W = 9 * LEVELS;
    localparam int unsigned PA_W  = 56;
    localparam int unsigned LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int unsigned IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
    localparam logic [3:0]  SATP_MODE = (LEVELS == 4) ? 4'd9 : 4'd8;

    typedef enum logic [2:0] {S_IDLE, S_WALK, S_PHY, S_FAULT, S_CLEANUP} state_e;

    state_e                 state_q, state_d;
    logic [LVL_W-1:0]       level_q, level_d;
    cbus_req_t              req_phys_q, req_phys_d;
    cbus_resp_t             resp_virt_q, resp_virt_d;
    logic                   skip_q, skip_d, page_fault_q, page_fault_d;
    logic                   ready_q, no_fill_q, no_fill_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [TLB_ENTRIES-1:0] tlb_valid_q, tlb_valid_d;
    logic [VPN_W-1:0]       tlb_vpn_q [TLB_ENTRIES];
    logic [VPN_W-1:0]       tlb_vpn_d [TLB_ENTRIES];
    logic [43:0]            tlb_ppn_q [TLB_ENTRIES];
    logic [43:0]            tlb_ppn_d [TLB_ENTRIES];
    logic [LVL_W-1:0]       tlb_lvl_q [TLB_ENTRIES];
    logic [LVL_W-1:0]       tlb_lvl_d [TLB_ENTRIES];
    pte_flags_t             tlb_flg_q [TLB_ENTRIES];
    pte_flags_t             tlb_flg_d [TLB_ENTRIES];

    logic             phy_ready_c, hit_c, bare_c, unused_bits;
    logic [IDX_W-1:0] hit_idx_c;
    logic [VPN_W-1:0] va_vpn_c;
    logic [63:0]      pte_c;
    logic [43:0]      pte_ppn_c;
    pte_flags_t       pte_flg_c;
    logic [PA_W-1:0]  hit_pa_c, walk_pa_c;

    function automatic logic perm_ok(input pte_flags_t f, input logic wr, input logic [1:0] priv);
        logic ok;
        ok = f.a;
        if (wr && !(f.w && f.d))       ok = 1'b0;
        if (!wr && !(f.r || f.x))      ok = 1'b0;
        if (priv == PRIV_U && !f.u)    ok = 1'b0;
        if (priv == PRIV_S && f.u)     ok = 1'b0;
        return ok;
    endfunction

    // Superpage translation: low 9*lvl PPN bits come from the VA.
    function automatic logic [PA_W-1:0] compose_pa(input logic [43:0] ppn, input logic [63:0] va,
                                                   input logic [LVL_W-1:0] lvl);
        logic [PA_W-1:0] m;
        m = (PA_W'(1) << (32'd12 + 32'd9 * 32'(lvl))) - PA_W'(1);
        return ({ppn, 12'h000} & ~m) | (va[PA_W-1:0] & m);
    endfunction

    function automatic logic [8:0] vpn_slice(input logic [VPN_W-1:0] v, input logic [LVL_W-1:0] lvl);
        return 9'(v >> (32'd9 * 32'(lvl)));
    endfunction

    function automatic logic vpn_match(input logic [VPN_W-1:0] a, input logic [VPN_W-1:0] b,
                                       input logic [LVL_W-1:0] lvl);
        logic [VPN_W-1:0] m;
        m = ~((VPN_W'(1) << (32'd9 * 32'(lvl))) - VPN_W'(1));
        return (a & m) == (b & m);
    endfunction

    assign phy_ready_c = resp_phys.ready & resp_phys.last & ~ready_q;
    assign va_vpn_c    = req_virt.addr[12 +: VPN_W];
    assign bare_c      = (priviledge_mode == PRIV_M) || (satp[63:60] == 4'd0);
    assign pte_c       = resp_phys.data;
    assign pte_ppn_c   = pte_c[53:10];
    assign pte_flg_c   = '{d: pte_c[7], a: pte_c[6], u: pte_c[4], x: pte_c[3], w: pte_c[2], r: pte_c[1]};
    assign walk_pa_c   = compose_pa(pte_ppn_c, req_virt.addr, level_q);
    assign hit_pa_c    = compose_pa(tlb_ppn_q[hit_idx_c], req_virt.addr, tlb_lvl_q[hit_idx_c]);
    assign unused_bits = ^{satp[59:44], pte_c[63:54], pte_c[9:8], pte_c[5]};

    // First-match TLB lookup.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (!hit_c && tlb_valid_q[i] && vpn_match(tlb_vpn_q[i], va_vpn_c, tlb_lvl_q[i])) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        req_phys_d   = req_phys_q;
        resp_virt_d  = resp_virt_q;
        skip_d       = skip_q;
        page_fault_d = page_fault_q;
        no_fill_d    = no_fill_q;
        ptr_d        = ptr_q;
        tlb_valid_d  = tlb_valid_q;
        tlb_vpn_d    = tlb_vpn_q;
        tlb_ppn_d    = tlb_ppn_q;
        tlb_lvl_d    = tlb_lvl_q;
        tlb_flg_d    = tlb_flg_q;
        unique case (state_q)
            S_IDLE: if (req_virt.valid) begin
                if (bare_c) begin
                    req_phys_d = req_virt;
                    skip_d     = 1'b0;
                    state_d    = S_PHY;
                end else if (satp[63:60] != SATP_MODE) begin
                    req_phys_d.valid = 1'b0;
                    state_d          = S_FAULT;
                end else if (hit_c) begin
                    if (perm_ok(tlb_flg_q[hit_idx_c], req_virt.is_write, priviledge_mode)) begin
                        req_phys_d      = req_virt;
                        req_phys_d.addr = 64'(hit_pa_c);
                        skip_d          = ~hit_pa_c[31];
                        state_d         = S_PHY;
                    end else begin
                        req_phys_d.valid = 1'b0;
                        state_d          = S_FAULT;
                    end
                end else begin
                    req_phys_d       = '0;
                    req_phys_d.valid = 1'b1;
                    req_phys_d.size  = MSIZE8;
                    req_phys_d.addr  = 64'({satp[43:0], vpn_slice(va_vpn_c, LVL_W'(LEVELS - 1)), 3'b000});
                    level_d          = LVL_W'(LEVELS - 1);
                    no_fill_d        = 1'b0;
                    state_d          = S_WALK;
                end
            end
            S_WALK: begin
                if (!req_virt.valid) begin
                    req_phys_d.valid = 1'b0;
                    state_d          = S_CLEANUP;
                end else if (phy_ready_c) begin
                    if (!pte_c[0] || (!pte_flg_c.r && pte_flg_c.w)) begin
                        req_phys_d.valid = 1'b0;
                        state_d          = S_FAULT;
                    end else if (!pte_flg_c.r && !pte_flg_c.x) begin
                        if (level_q == '0) begin
                            req_phys_d.valid = 1'b0;
                            state_d          = S_FAULT;
                        end else begin
                            level_d         = level_q - LVL_W'(1);
                            req_phys_d.addr = 64'({pte_ppn_c, vpn_slice(va_vpn_c, level_q - LVL_W'(1)), 3'b000});
                        end
                    end else if ((pte_ppn_c & ((44'(1) << (32'd9 * 32'(level_q))) - 44'(1))) != '0
                                 || !perm_ok(pte_flg_c, req_virt.is_write, priviledge_mode)) begin
                        req_phys_d.valid = 1'b0;
                        state_d          = S_FAULT;
                    end else begin
                        if (!no_fill_q && !sfence) begin
                            tlb_valid_d[ptr_q] = 1'b1;
                            tlb_vpn_d[ptr_q]   = va_vpn_c;
                            tlb_ppn_d[ptr_q]   = pte_ppn_c;
                            tlb_lvl_d[ptr_q]   = level_q;
                            tlb_flg_d[ptr_q]   = pte_flg_c;
                            ptr_d = (ptr_q == IDX_W'(TLB_ENTRIES - 1)) ? '0 : ptr_q + IDX_W'(1);
                        end
                        req_phys_d      = req_virt;
                        req_phys_d.addr = 64'(walk_pa_c);
                        skip_d          = ~walk_pa_c[31];
                        state_d         = S_PHY;
                    end
                end
            end
            S_PHY: begin
                if (!req_virt.valid) begin
                    req_phys_d.valid = 1'b0;
                    state_d          = S_CLEANUP;
                end else if (phy_ready_c) begin
                    resp_virt_d      = resp_phys;
                    req_phys_d.valid = 1'b0;
                    state_d          = S_CLEANUP;
                end
            end
            S_FAULT: begin
                req_phys_d.valid = 1'b0;
                resp_virt_d      = '{ready: 1'b1, last: 1'b1, data: 64'd0};
                page_fault_d     = 1'b1;
                state_d          = S_CLEANUP;
            end
            S_CLEANUP: begin
                resp_virt_d  = '0;
                skip_d       = 1'b0;
                page_fault_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A flush mid-walk must also keep the in-flight translation out of the TLB.
        if (sfence) begin
            tlb_valid_d = '0;
            if (state_q == S_WALK) no_fill_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            level_q      <= '0;
            req_phys_q   <= '0;
            resp_virt_q  <= '0;
            skip_q       <= 1'b0;
            page_fault_q <= 1'b0;
            ready_q      <= 1'b0;
            no_fill_q    <= 1'b0;
            ptr_q        <= '0;
            tlb_valid_q  <= '0;
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tlb_vpn_q[i] <= '0;
                tlb_ppn_q[i] <= '0;
                tlb_lvl_q[i] <= '0;
                tlb_flg_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            req_phys_q   <= req_phys_d;
            resp_virt_q  <= resp_virt_d;
            skip_q       <= skip_d;
            page_fault_q <= page_fault_d;
            ready_q      <= resp_phys.ready;
            no_fill_q    <= no_fill_d;
            ptr_q        <= ptr_d;
            tlb_valid_q  <= tlb_valid_d;
            tlb_vpn_q    <= tlb_vpn_d;
            tlb_ppn_q    <= tlb_ppn_d;
            tlb_lvl_q    <= tlb_lvl_d;
            tlb_flg_q    <= tlb_flg_d;
        end
    end

    assign req_phys   = req_phys_q;
    assign resp_virt  = resp_virt_q;
    assign skip       = skip_q;
    assign page_fault = page_fault_q;
endmodule

// File: tb/tb_mmu_tlb_walker.sv
// Scoreboard bench for mmu_tlb_walker: sparse-memory responder holding Sv39 page tables,
// expected completions queued at issue and compared when resp_virt fires.
module tb_mmu_tlb_walker;
    import mmu_tlb_walker_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] satp;
    logic [1:0]  priv;
    logic        sfence;
    cbus_req_t   req_virt;
    cbus_resp_t  resp_virt;
    cbus_req_t   req_phys;
    cbus_resp_t  resp_phys;
    logic        skip;
    logic        page_fault;

    mmu_tlb_walker #(.LEVELS(3), .TLB_ENTRIES(4)) dut (
        .clk(clk), .rst_n(rst_n), .satp(satp), .priviledge_mode(priv), .sfence(sfence),
        .req_virt(req_virt), .resp_virt(resp_virt), .req_phys(req_phys),
        .resp_phys(resp_phys), .skip(skip), .page_fault(page_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pf;
        logic [63:0] pa;
        int          reads_base;
        int          reads;
        logic        skp;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem [logic [63:0]];
    int          n_vec = 0;
    int          n_err = 0;
    int          pte_reads = 0;
    int          resp_seen = 0;
    logic [63:0] last_pa = '0;

    localparam logic [63:0] SATP_SV39 = {4'd8, 16'd0, 44'h81000};
    localparam logic [63:0] FL_VRWAD  = 64'hC7;
    localparam logic [63:0] FL_VRWA   = 64'h47;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pattern(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEADBEEF, a[31:0]};
    endfunction

    function automatic logic is_pt(input logic [63:0] a);
        return a[63:20] == 44'h810;
    endfunction

    task automatic set_pte(input logic [43:0] table_ppn, input int idx, input logic [63:0] val);
        mem[{8'h0, table_ppn, 12'h000} + 64'(idx * 8)] = val;
    endtask

    function automatic logic [63:0] leaf(input logic [43:0] ppn, input logic [63:0] fl);
        return {10'h0, ppn, 10'h0} | fl;
    endfunction

    // Memory: fixed 3-cycle latency, one-cycle ready/last pulse, idle cycle between beats.
    initial begin
        int          cnt;
        logic        gap;
        logic [63:0] a;
        resp_phys = '0;
        cnt = 0;
        gap = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp_phys = '0; cnt = 0; gap = 1'b0;
            end else if (resp_phys.ready) begin
                resp_phys = '0; gap = 1'b1;
            end else if (gap) begin
                gap = 1'b0;
            end else if (req_phys.valid) begin
                if (cnt == 2) begin
                    cnt = 0;
                    a = req_phys.addr;
                    resp_phys.ready = 1'b1;
                    resp_phys.last  = 1'b1;
                    if (is_pt(a)) begin
                        pte_reads++;
                        resp_phys.data = mem.exists(a) ? mem[a] : 64'd0;
                    end else begin
                        last_pa = a;
                        resp_phys.data = pattern(a);
                    end
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Scoreboard: pop one expectation per completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_virt.ready) begin
                resp_seen++;
                if (sb.size() == 0) begin
                    check_eq("spurious_resp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("page_fault", 64'(page_fault), 64'(e.pf));
                    check_eq("resp_data", resp_virt.data, e.pf ? 64'd0 : pattern(e.pa));
                    check_eq("resp_last", 64'(resp_virt.last), 64'd1);
                    check_eq("pte_reads", 64'(pte_reads - e.reads_base), 64'(e.reads));
                    check_eq("skip", 64'(skip), 64'(e.skp));
                    if (!e.pf) check_eq("phys_addr", last_pa, e.pa);
                end
            end
        end
    end

    task automatic launch(input logic [63:0] va, input logic wr, input logic [1:0] p);
        @(negedge clk);
        req_virt          = '0;
        req_virt.valid    = 1'b1;
        req_virt.is_write = wr;
        req_virt.size     = MSIZE8;
        req_virt.addr     = va;
        req_virt.strobe   = wr ? 8'hFF : 8'h00;
        req_virt.data     = 64'h1234_5678_9ABC_DEF0;
        priv              = p;
    endtask

    task automatic do_access(input logic [63:0] va, input logic wr, input logic [1:0] p,
                             input logic pf, input logic [63:0] pa, input int reads,
                             input logic skp, input int sf_at);
        exp_t e;
        logic got;
        e.pf = pf; e.pa = pa; e.reads_base = pte_reads; e.reads = reads; e.skp = skp;
        sb.push_back(e);
        launch(va, wr, p);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            sfence = (i == sf_at);
            if (resp_virt.ready) got = 1'b1;
        end
        sfence = 1'b0;
        if (!got) check_eq("resp_timeout", 64'd0, 64'd1);
        req_virt.valid = 1'b0;
        @(negedge clk);
        check_eq("resp_one_cycle", 64'(resp_virt.ready), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_virt = '0;
        sfence = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen0;
        logic found;
        satp = SATP_SV39;
        priv = PRIV_S;
        // Root 0x81000 -> L1 0x81001 -> L0 0x81002
        set_pte(44'h81000, 0, {10'h0, 44'h81001, 10'h0} | 64'h1);
        set_pte(44'h81001, 2, {10'h0, 44'h81002, 10'h0} | 64'h1);
        set_pte(44'h81002, 0, leaf(44'h80200, FL_VRWAD));
        set_pte(44'h81002, 1, leaf(44'h80201, FL_VRWA));
        set_pte(44'h81002, 2, leaf(44'h10000, FL_VRWAD));
        for (int k = 0; k < 5; k++) set_pte(44'h81002, 8 + k, leaf(44'h80300 + 44'(k), FL_VRWAD));
        set_pte(44'h81001, 3, leaf(44'h80400, FL_VRWAD));
        set_pte(44'h81001, 4, leaf(44'h80401, FL_VRWAD));

        do_reset();
        check_eq("rst_req_valid", 64'(req_phys.valid), 64'd0);
        check_eq("rst_req_addr", req_phys.addr, 64'd0);
        check_eq("rst_resp_ready", 64'(resp_virt.ready), 64'd0);
        check_eq("rst_pf_skip", 64'({page_fault, skip}), 64'd0);

        do_access(64'h8000_0000, 1'b0, PRIV_M, 1'b0, 64'h8000_0000, 0, 1'b0, -1);
        do_access(64'h40_0123, 1'b0, PRIV_S, 1'b0, 64'h8020_0123, 3, 1'b0, -1);
        do_access(64'h40_0123, 1'b0, PRIV_S, 1'b0, 64'h8020_0123, 0, 1'b0, -1);
        do_access(64'h61_2345, 1'b0, PRIV_S, 1'b0, 64'h8041_2345, 2, 1'b0, -1);
        do_access(64'h7F_FFF8, 1'b0, PRIV_S, 1'b0, 64'h805F_FFF8, 0, 1'b0, -1);
        do_access(64'h80_0010, 1'b0, PRIV_S, 1'b1, 64'd0, 2, 1'b0, -1);
        do_access(64'h80_0010, 1'b0, PRIV_S, 1'b1, 64'd0, 2, 1'b0, -1);
        do_access(64'h40_1008, 1'b1, PRIV_S, 1'b1, 64'd0, 3, 1'b0, -1);
        do_access(64'h40_1008, 1'b0, PRIV_S, 1'b0, 64'h8020_1008, 3, 1'b0, -1);
        do_access(64'h40_0123, 1'b0, PRIV_U, 1'b1, 64'd0, 0, 1'b0, -1);
        do_access(64'h40_2004, 1'b0, PRIV_S, 1'b0, 64'h1000_0004, 3, 1'b1, -1);
        satp = {4'd9, SATP_SV39[59:0]};
        do_access(64'h40_0123, 1'b0, PRIV_S, 1'b1, 64'd0, 0, 1'b0, -1);
        satp = SATP_SV39;

        // Round-robin replacement from a clean TLB
        do_reset();
        for (int k = 0; k < 5; k++)
            do_access(64'h40_8010 + 64'(k << 12), 1'b0, PRIV_S, 1'b0, 64'h8030_0010 + 64'(k << 12), 3, 1'b0, -1);
        for (int k = 1; k < 5; k++)
            do_access(64'h40_8010 + 64'(k << 12), 1'b0, PRIV_S, 1'b0, 64'h8030_0010 + 64'(k << 12), 0, 1'b0, -1);
        do_access(64'h40_8010, 1'b0, PRIV_S, 1'b0, 64'h8030_0010, 3, 1'b0, -1);
        @(negedge clk); sfence = 1'b1;
        @(negedge clk); sfence = 1'b0;
        do_access(64'h40_A010, 1'b0, PRIV_S, 1'b0, 64'h8030_2010, 3, 1'b0, -1);
        do_access(64'h40_B010, 1'b0, PRIV_S, 1'b0, 64'h8030_3010, 3, 1'b0, 1);
        do_access(64'h40_B010, 1'b0, PRIV_S, 1'b0, 64'h8030_3010, 3, 1'b0, -1);

        // Abandon a walk part way through
        seen0 = resp_seen;
        launch(64'h40_C010, 1'b0, PRIV_S);
        repeat (5) @(negedge clk);
        req_virt.valid = 1'b0;
        @(negedge clk);
        check_eq("drop_req_valid", 64'(req_phys.valid), 64'd0);
        repeat (10) @(negedge clk);
        check_eq("drop_no_resp", 64'(resp_seen - seen0), 64'd0);
        do_access(64'h40_C010, 1'b0, PRIV_S, 1'b0, 64'h8030_4010, 3, 1'b0, -1);

        // Asynchronous reset while the translated MMIO access is outstanding
        do_reset();
        launch(64'h40_2004, 1'b0, PRIV_S);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (req_phys.valid && req_phys.addr == 64'h1000_0004) found = 1'b1;
        end
        check_eq("phy_reached", 64'(found), 64'd1);
        check_eq("phy_skip", 64'(skip), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_req_valid", 64'(req_phys.valid), 64'd0);
        check_eq("arst_req_addr", req_phys.addr, 64'd0);
        check_eq("arst_skip", 64'(skip), 64'd0);
        check_eq("arst_resp", 64'({resp_virt.ready, page_fault}), 64'd0);
        req_virt.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
